// File: rtl/raman_acq_sequencer_if.sv
// Bundle of sync/strobe/dump signals between the Raman sweep sequencer and its host.
// sweep_ts is present only when SEQ_TIMESTAMP_EN is defined.
interface raman_acq_sequencer_if #(
    parameter int PT_W = 11,
    parameter int MS_W = 17,
    parameter int SV_W = 4
);
    logic            run_en;
    logic            sync;
    logic            fifo_wrreq;
    logic            fifo_rdreq;
    logic            acc_en;
    logic            acc_first;
    logic [PT_W-1:0] point_idx;
    logic [MS_W-1:0] measure_cnt;
    logic [SV_W-1:0] save_cnt;
    // dump_req is the valid: it rises once per set and holds until a cycle with dump_ack (ready) high.
    logic            dump_req;
    logic            dump_ack;
    logic            busy;
    logic            overrun;
    logic [1:0]      state_dbg;
`ifdef SEQ_TIMESTAMP_EN
    logic [31:0]     sweep_ts;
`endif

    modport seq (
        input  run_en, sync, dump_ack,
        output fifo_wrreq, fifo_rdreq, acc_en, acc_first, point_idx,
        output measure_cnt, save_cnt, dump_req, busy, overrun, state_dbg
`ifdef SEQ_TIMESTAMP_EN
        , output sweep_ts
`endif
    );

    modport host (
        output run_en, sync, dump_ack,
        input  fifo_wrreq, fifo_rdreq, acc_en, acc_first, point_idx,
        input  measure_cnt, save_cnt, dump_req, busy, overrun, state_dbg
`ifdef SEQ_TIMESTAMP_EN
        , input sweep_ts
`endif
    );
endinterface

// File: rtl/raman_acq_sequencer.sv
// Per-sweep Raman acquisition sequencer: FIFO write/read strobes, accumulator strobes, set dumps.
// Define SEQ_TIMESTAMP_EN to add the sweep_ts capture of a free-running cycle counter.
module raman_acq_sequencer #(
    parameter int POINTS   = 10,
    parameter int MEASURES = 100,
    parameter int SAVES    = 10,
    parameter int RD_DELAY = 3,
    parameter int PT_W     = 11,
    parameter int MS_W     = 17,
    parameter int SV_W     = 4
) (
    input logic                clk,
    input logic                rst_n,
    raman_acq_sequencer_if.seq bus
);
    // One extra bit so the cycle counter reaches POINTS+RD_DELAY without wrapping.
    localparam int CYC_W = PT_W + 1;
    localparam logic [CYC_W-1:0] WR_END    = CYC_W'(POINTS);
    localparam logic [CYC_W-1:0] RD_START  = CYC_W'(RD_DELAY);
    localparam logic [CYC_W-1:0] RD_END    = CYC_W'(POINTS + RD_DELAY);
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(POINTS + RD_DELAY);
    localparam logic [MS_W-1:0]  MEAS_LAST = MS_W'(MEASURES - 1);
    localparam logic [SV_W-1:0]  SAVE_LAST = SV_W'(SAVES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DUMP = 2'd2} state_e;

    state_e          state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic            sync_dly_q, sync_dly_d;
    logic            wrreq_q, wrreq_d;
    logic            rdreq_q, rdreq_d;
    logic            acc_en_q, acc_en_d;
    logic            acc_first_q, acc_first_d;
    logic [PT_W-1:0] point_idx_q, point_idx_d;
    logic [MS_W-1:0] measure_q, measure_d;
    logic [SV_W-1:0] save_q, save_d;
    logic            dump_req_q, dump_req_d;
    logic            overrun_q, overrun_d;
    logic            sync_edge;
    logic            accept;

    assign sync_edge = bus.sync & ~sync_dly_q;
    assign accept    = (state_q == IDLE) && bus.run_en && sync_edge;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        measure_d  = measure_q;
        save_d     = save_q;
        dump_req_d = dump_req_q;
        overrun_d  = overrun_q;
        sync_dly_d = bus.sync;
        case (state_q)
            IDLE: begin
                if (!bus.run_en) begin
                    measure_d = '0;
                    overrun_d = 1'b0;
                end else if (accept) begin
                    state_d = SWEEP;
                    cyc_d   = '0;
                end
            end
            SWEEP: begin
                if (sync_edge) overrun_d = 1'b1;
                // The last acc_en cycle is cyc == CYC_LAST; the sweep closes there.
                if (cyc_q == CYC_LAST) begin
                    if (measure_q == MEAS_LAST) begin
                        state_d    = DUMP;
                        dump_req_d = 1'b1;
                    end else begin
                        measure_d = measure_q + MS_W'(1);
                        state_d   = IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            DUMP: begin
                if (sync_edge) overrun_d = 1'b1;
                if (bus.dump_ack) begin
                    dump_req_d = 1'b0;
                    measure_d  = '0;
                    save_d     = (save_q == SAVE_LAST) ? '0 : save_q + SV_W'(1);
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Strobes are registered from the next cycle index so they line up with cyc_q.
        wrreq_d     = (state_d == SWEEP) && (cyc_d < WR_END);
        rdreq_d     = (state_d == SWEEP) && (cyc_d >= RD_START) && (cyc_d < RD_END);
        acc_en_d    = rdreq_q;
        acc_first_d = rdreq_q && (measure_q == '0);
        point_idx_d = rdreq_q ? PT_W'(cyc_q - RD_START) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= '0;
            sync_dly_q  <= 1'b0;
            wrreq_q     <= 1'b0;
            rdreq_q     <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_first_q <= 1'b0;
            point_idx_q <= '0;
            measure_q   <= '0;
            save_q      <= '0;
            dump_req_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            sync_dly_q  <= sync_dly_d;
            wrreq_q     <= wrreq_d;
            rdreq_q     <= rdreq_d;
            acc_en_q    <= acc_en_d;
            acc_first_q <= acc_first_d;
            point_idx_q <= point_idx_d;
            measure_q   <= measure_d;
            save_q      <= save_d;
            dump_req_q  <= dump_req_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.fifo_wrreq  = wrreq_q;
    assign bus.fifo_rdreq  = rdreq_q;
    assign bus.acc_en      = acc_en_q;
    assign bus.acc_first   = acc_first_q;
    assign bus.point_idx   = point_idx_q;
    assign bus.measure_cnt = measure_q;
    assign bus.save_cnt    = save_q;
    assign bus.dump_req    = dump_req_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.overrun     = overrun_q;
    assign bus.state_dbg   = state_q;

`ifdef SEQ_TIMESTAMP_EN
    logic [31:0] ts_q, ts_d;
    logic [31:0] sweep_ts_q, sweep_ts_d;

    always_comb begin
        ts_d       = ts_q + 32'd1;
        sweep_ts_d = accept ? ts_q : sweep_ts_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            sweep_ts_q <= '0;
        end else begin
            ts_q       <= ts_d;
            sweep_ts_q <= sweep_ts_d;
        end
    end

    assign bus.sweep_ts = sweep_ts_q;
`endif
endmodule

// File: tb/tb_raman_acq_sequencer.sv
// Directed bench: dut_a (POINTS=10, RD_DELAY=3, MEASURES=3, SAVES=2), dut_b (MEASURES=1, SAVES=2).
module tb_raman_acq_sequencer;
    localparam int PT_W = 11;
    localparam int MS_W = 17;
    localparam int SV_W = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    raman_acq_sequencer_if #(.PT_W(PT_W), .MS_W(MS_W), .SV_W(SV_W)) if_a ();
    raman_acq_sequencer_if #(.PT_W(PT_W), .MS_W(MS_W), .SV_W(SV_W)) if_b ();

    raman_acq_sequencer #(
        .POINTS(10), .MEASURES(3), .SAVES(2), .RD_DELAY(3),
        .PT_W(PT_W), .MS_W(MS_W), .SV_W(SV_W)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );

    raman_acq_sequencer #(
        .POINTS(10), .MEASURES(1), .SAVES(2), .RD_DELAY(3),
        .PT_W(PT_W), .MS_W(MS_W), .SV_W(SV_W)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );

    typedef struct packed {
        logic            wr;
        logic            rd;
        logic            acc;
        logic            first;
        logic            busy;
        logic [PT_W-1:0] idx;
        logic [MS_W-1:0] meas;
    } exp_t;

    typedef struct packed {
        logic sync;
        exp_t exp;
    } vec_t;

    vec_t            tbl[16];
    logic [SV_W-1:0] exp_q[$];

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, got, exp);
        end
    endtask

    function automatic vec_t row(input logic s, input logic wr, input logic rd, input logic acc,
                                 input logic first, input logic busy, input int idx, input int meas);
        vec_t r;
        r.sync       = s;
        r.exp.wr     = wr;
        r.exp.rd     = rd;
        r.exp.acc    = acc;
        r.exp.first  = first;
        r.exp.busy   = busy;
        r.exp.idx    = PT_W'(idx);
        r.exp.meas   = MS_W'(meas);
        return r;
    endfunction

    function automatic logic [63:0] all_outs_a();
        return {25'd0, if_a.fifo_wrreq, if_a.fifo_rdreq, if_a.acc_en, if_a.acc_first,
                if_a.dump_req, if_a.busy, if_a.overrun, if_a.point_idx, if_a.measure_cnt,
                if_a.save_cnt};
    endfunction

    // driver tasks
    task automatic apply_table(input string tag);
        for (int k = 0; k < 16; k++) begin
            if_a.sync = tbl[k].sync;
            tick();
            check($sformatf("%s_r%0d_strobes", tag, k),
                  {if_a.fifo_wrreq, if_a.fifo_rdreq, if_a.acc_en, if_a.acc_first, if_a.busy},
                  {tbl[k].exp.wr, tbl[k].exp.rd, tbl[k].exp.acc, tbl[k].exp.first, tbl[k].exp.busy});
            check($sformatf("%s_r%0d_meas", tag, k), if_a.measure_cnt, tbl[k].exp.meas);
            if (tbl[k].exp.acc)
                check($sformatf("%s_r%0d_idx", tag, k), if_a.point_idx, tbl[k].exp.idx);
        end
    endtask

    task automatic run_sweep(input int sync2_k, input int runoff_k,
                             output int nwr, output int nrd, output int nacc, output int nfirst);
        nwr = 0; nrd = 0; nacc = 0; nfirst = 0;
        for (int k = 0; k < 15; k++) begin
            if_a.sync = (k == 0) || (k == sync2_k);
            if (k == runoff_k) if_a.run_en = 1'b0;
            tick();
            nwr    += int'(if_a.fifo_wrreq);
            nrd    += int'(if_a.fifo_rdreq);
            nacc   += int'(if_a.acc_en);
            nfirst += int'(if_a.acc_en & if_a.acc_first);
        end
        if_a.sync = 1'b0;
    endtask

    initial begin
        int nwr, nrd, nacc, nfirst, nbusy;

        rst_n = 1'b0;
        if_a.run_en = 1'b0; if_a.sync = 1'b0; if_a.dump_ack = 1'b0;
        if_b.run_en = 1'b0; if_b.sync = 1'b0; if_b.dump_ack = 1'b0;

        // One sweep from IDLE with measure_cnt = 0: k is cycles since the sync edge was sampled.
        tbl[0]  = row(1, 1, 0, 0, 0, 1, 0, 0);
        tbl[1]  = row(0, 1, 0, 0, 0, 1, 0, 0);
        tbl[2]  = row(0, 1, 0, 0, 0, 1, 0, 0);
        tbl[3]  = row(0, 1, 1, 0, 0, 1, 0, 0);
        tbl[4]  = row(0, 1, 1, 1, 1, 1, 0, 0);
        tbl[5]  = row(0, 1, 1, 1, 1, 1, 1, 0);
        tbl[6]  = row(0, 1, 1, 1, 1, 1, 2, 0);
        tbl[7]  = row(0, 1, 1, 1, 1, 1, 3, 0);
        tbl[8]  = row(0, 1, 1, 1, 1, 1, 4, 0);
        tbl[9]  = row(0, 1, 1, 1, 1, 1, 5, 0);
        tbl[10] = row(0, 0, 1, 1, 1, 1, 6, 0);
        tbl[11] = row(0, 0, 1, 1, 1, 1, 7, 0);
        tbl[12] = row(0, 0, 1, 1, 1, 1, 8, 0);
        tbl[13] = row(0, 0, 0, 1, 1, 1, 9, 0);
        tbl[14] = row(0, 0, 0, 0, 0, 0, 0, 1);
        tbl[15] = row(0, 0, 0, 0, 0, 0, 0, 1);

        repeat (3) tick();
        check("reset_outs", all_outs_a(), 64'd0);
        rst_n = 1'b1;
        tick();
        check("post_reset_outs", all_outs_a(), 64'd0);
        check("post_reset_state", if_a.state_dbg, 64'd0);

        // dump_ack outside DUMP has no effect
        if_a.run_en = 1'b1;
        if_a.dump_ack = 1'b1;
        tick();
        if_a.dump_ack = 1'b0;
        check("stray_ack_save", if_a.save_cnt, 64'd0);
        check("stray_ack_busy", if_a.busy, 64'd0);

        apply_table("sweep1");

        repeat (15) tick();
        run_sweep(-1, -1, nwr, nrd, nacc, nfirst);
        check("sweep2_wr", nwr, 10);
        check("sweep2_rd", nrd, 10);
        check("sweep2_acc", nacc, 10);
        check("sweep2_first", nfirst, 0);
        check("sweep2_meas", if_a.measure_cnt, 2);
        check("sweep2_busy", if_a.busy, 0);

        repeat (15) tick();
        run_sweep(-1, -1, nwr, nrd, nacc, nfirst);
        check("sweep3_acc", nacc, 10);
        check("sweep3_first", nfirst, 0);
        check("sweep3_dump_req", if_a.dump_req, 1);
        check("sweep3_busy", if_a.busy, 1);
        check("sweep3_meas", if_a.measure_cnt, 2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("dump_hold%0d", i), if_a.dump_req, 1);
        end
        if_a.dump_ack = 1'b1;
        tick();
        if_a.dump_ack = 1'b0;
        check("dump_done_req", if_a.dump_req, 0);
        check("dump_done_meas", if_a.measure_cnt, 0);
        check("dump_done_save", if_a.save_cnt, 1);
        check("dump_done_busy", if_a.busy, 0);

        // sync edge mid-sweep: ignored but flagged
        tick();
        run_sweep(5, -1, nwr, nrd, nacc, nfirst);
        check("ovr_wr", nwr, 10);
        check("ovr_rd", nrd, 10);
        check("ovr_flag", if_a.overrun, 1);
        check("ovr_meas", if_a.measure_cnt, 1);
        repeat (3) tick();
        check("ovr_sticky", if_a.overrun, 1);
        if_a.run_en = 1'b0;
        tick();
        check("runoff_clr_ovr", if_a.overrun, 0);
        check("runoff_clr_meas", if_a.measure_cnt, 0);

        // run_en drops mid-sweep: sweep completes, later sync ignored
        if_a.run_en = 1'b1;
        tick();
        run_sweep(-1, 3, nwr, nrd, nacc, nfirst);
        check("halt_wr", nwr, 10);
        check("halt_rd", nrd, 10);
        check("halt_first", nfirst, 10);
        check("halt_busy", if_a.busy, 0);
        check("halt_meas_inc", if_a.measure_cnt, 1);
        tick();
        check("halt_meas_clr", if_a.measure_cnt, 0);
        if_a.sync = 1'b1;
        nbusy = 0; nwr = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if_a.sync = 1'b0;
            nbusy += int'(if_a.busy);
            nwr   += int'(if_a.fifo_wrreq);
        end
        check("halt_sync_busy", nbusy, 0);
        check("halt_sync_wr", nwr, 0);
        check("halt_sync_ovr", if_a.overrun, 0);

        // async reset mid-sweep (save_cnt is 1 beforehand)
        if_a.run_en = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            if_a.sync = (k == 0);
            tick();
        end
        check("pre_rst_wr", if_a.fifo_wrreq, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs", all_outs_a(), 64'd0);
        check("mid_rst_state", if_a.state_dbg, 0);
        tick();
        rst_n = 1'b1;
        tick();
        apply_table("after_rst");

        // MEASURES=1: every sweep dumps, acc_first always set, save_cnt wraps at 2
        exp_q.push_back(SV_W'(1));
        exp_q.push_back(SV_W'(0));
        exp_q.push_back(SV_W'(1));
        if_b.run_en = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            nacc = 0; nfirst = 0;
            if_b.sync = 1'b1;
            for (int k = 0; k < 15; k++) begin
                tick();
                if_b.sync = 1'b0;
                nacc   += int'(if_b.acc_en);
                nfirst += int'(if_b.acc_en & if_b.acc_first);
            end
            check($sformatf("m1_s%0d_acc", s), nacc, 10);
            check($sformatf("m1_s%0d_first", s), nfirst, 10);
            check($sformatf("m1_s%0d_dump_req", s), if_b.dump_req, 1);
            if_b.dump_ack = 1'b1;
            tick();
            if_b.dump_ack = 1'b0;
            check($sformatf("m1_s%0d_save", s), if_b.save_cnt, exp_q.pop_front());
            check($sformatf("m1_s%0d_req_low", s), if_b.dump_req, 0);
            check($sformatf("m1_s%0d_meas", s), if_b.measure_cnt, 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
